seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; the next generation of the team's fixed two-bit Mealy detectors.
- Matches a PAT_W-bit pattern, supplied at run time, on a qualified serial input.
- Supports overlapping and non-overlapping match modes, a saturating match counter and a synchronous clear.
- Sits behind serial front-ends (UART/line decoders) as a framing/sync-word detector.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..32.
- CNT_W, 8, width of the match counter; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  one clock; reset is asynchronous and active-high.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled on a clk edge only when high.
- pattern  input  PAT_W  target pattern; pattern[PAT_W-1] is the first bit received, pattern[0] the last.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- clear  input  1  synchronous flush of history, counter and y.
- y  output  1  registered match pulse.
- match_cnt  output  CNT_W  number of matches since reset/clear, saturating.
- cnt_sat  output  1  high while match_cnt is all-ones.

Behaviour:
- Reset (async, rst=1): window=0, fill=0, y=0, match_cnt=0, cnt_sat=0. Outputs hold these values while rst is high. The first sample is taken at the first edge after rst falls.
- State: PAT_W-bit shift window of received bits, plus a fill counter 0..PAT_W saturating at PAT_W. Fill is the number of valid history bits.
- Priority per edge, when not in reset: clear > x_valid > idle.
- Edge with clear=1: fill<=0, window<=0, match_cnt<=0, y<=0. x is ignored, even if x_valid=1.
- Edge with x_valid=1 and clear=0:
  - nw = {window[PAT_W-2:0], x}; nf = min(fill+1, PAT_W).
  - hit = (nf==PAT_W) && (nw==pattern).
  - y<=hit, window<=nw.
  - If hit and overlap=1: fill<=nf.
  - If hit and overlap=0: fill<=0. The next match needs PAT_W fresh bits.
  - If hit and match_cnt != all-ones: match_cnt<=match_cnt+1. Otherwise it holds (no wrap).
  - If no hit: fill<=nf.
- Edge with x_valid=0 and clear=0: window, fill and match_cnt hold; y<=0. y is therefore always a single-cycle pulse.
- Latency: y rises in the cycle immediately after the edge that sampled the final pattern bit, i.e. 1 clk. This is a registered Mealy output.
- cnt_sat is combinational from match_cnt (match_cnt == 2^CNT_W-1).
- pattern and overlap are evaluated at every sampling edge, with no restart. A change applies to the next sample; already-received history is kept.
- Gaps: any number of x_valid=0 cycles between bits do not break a partial match.
- No false match before PAT_W bits have been received after reset or clear, even if pattern is all zeros.
- Reset mid-pattern discards the partial history; the pattern must be received fully again.

Test Plan:
- PAT_W=4, pattern=1011, overlap=1, stream 1,0,1,1,0,1,1 with x_valid continuous -> y pulses after bit 4 and bit 7; match_cnt=2.
- Same stream, overlap=0 -> y pulses only after bit 4; match_cnt=1.
- pattern=1111, seven 1s: overlap=1 -> pulses after bits 4,5,6,7, match_cnt=4; overlap=0 -> pulse after bit 4 only, match_cnt=1 (bits 5-7 give fill=3).
- pattern=1011 delivered with x_valid low for 3 cycles between every bit -> exactly one y pulse, 1 clk wide, in the cycle after the last sampled bit.
- pattern=0000, reset, then three 0s -> y stays 0; fourth 0 -> y=1 (no premature match from reset history).
- CNT_W=2, overlap=1, pattern=1111, eight 1s -> match_cnt reaches 3 and stays 3, cnt_sat=1; then clear=1 together with x_valid=1 -> match_cnt=0, y=0, fill=0; 1,1,1 -> no pulse; fourth 1 -> pulse.
- Assert rst mid-stream after bits 1,0,1 of 1011, release, send 1 -> no pulse; send 1,0,1,1 -> pulse.

Source files
------------

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with a run-time pattern, overlap/non-overlap modes,
// a saturating match counter and a synchronous clear. y is a registered one-cycle pulse.
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_reg, window_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              y_reg, y_next;

    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill_inc;
    logic [PAT_W-1:0]  bit_eq;
    logic              hit;

    assign shifted  = {window_reg[PAT_W-2:0], x};
    assign fill_inc = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + FILL_W'(1);

    // Per-bit agreement between the candidate window and the target pattern
    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_eq[gi] = ~(shifted[gi] ^ pattern[gi]);
        end
    endgenerate

    // A window only counts once it holds PAT_W genuinely received bits
    assign hit = (fill_inc == FILL_FULL) && (&bit_eq);

    always_comb begin
        window_next = window_reg;
        fill_next   = fill_reg;
        cnt_next    = cnt_reg;
        y_next      = 1'b0;
        if (clear) begin
            window_next = '0;
            fill_next   = '0;
            cnt_next    = '0;
        end else if (x_valid) begin
            window_next = shifted;
            y_next      = hit;
            fill_next   = (hit && !overlap) ? '0 : fill_inc;
            if (hit && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_reg <= '0;
            fill_reg   <= '0;
            cnt_reg    <= '0;
            y_reg      <= 1'b0;
        end else begin
            window_reg <= window_next;
            fill_reg   <= fill_next;
            cnt_reg    <= cnt_next;
            y_reg      <= y_next;
        end
    end

    assign y         = y_reg;
    assign match_cnt = cnt_reg;
    assign cnt_sat   = (cnt_reg == {CNT_W{1'b1}});

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param: a wide-counter and a 2-bit-counter instance
// share the stimulus; expectations are queued at drive time and popped after each edge.
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       x;
    logic       x_valid;
    logic [3:0] pat;
    logic       ov;
    logic       clr;
    logic       y_a, y_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic       sat_a, sat_b;

    int total = 0;
    int bad   = 0;
    int pulses;

    typedef struct packed {
        logic       y;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
        logic       sat_a;
        logic       sat_b;
    } exp_t;

    exp_t sb_q[$];

    // Reference state
    logic [3:0] m_win;
    int         m_fill;
    int         m_cnt_a;
    int         m_cnt_b;

    seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pattern(pat),
        .overlap(ov), .clear(clr), .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pattern(pat),
        .overlap(ov), .clear(clr), .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_win   = 4'b0;
        m_fill  = 0;
        m_cnt_a = 0;
        m_cnt_b = 0;
    endtask

    // Drive one edge's inputs, queue the expectation, then compare after the edge
    task automatic step(input logic bx, input logic bv, input logic bc);
        exp_t e;
        logic [3:0] nw;
        int nf;
        logic hit;
        exp_t o;
        x = bx; x_valid = bv; clr = bc;
        hit = 1'b0;
        if (bc) begin
            model_reset();
        end else if (bv) begin
            nw  = {m_win[2:0], bx};
            nf  = (m_fill + 1 > 4) ? 4 : m_fill + 1;
            hit = (nf == 4) && (nw == pat);
            m_win  = nw;
            m_fill = (hit && !ov) ? 0 : nf;
            if (hit && m_cnt_a < 255) m_cnt_a++;
            if (hit && m_cnt_b < 3)   m_cnt_b++;
        end
        e.y     = hit;
        e.cnt_a = 8'(m_cnt_a);
        e.cnt_b = 2'(m_cnt_b);
        e.sat_a = (m_cnt_a == 255);
        e.sat_b = (m_cnt_b == 3);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk("y", 32'(y_a), 32'(o.y));
        chk("y_small", 32'(y_b), 32'(o.y));
        chk("cnt", 32'(cnt_a), 32'(o.cnt_a));
        chk("cnt_small", 32'(cnt_b), 32'(o.cnt_b));
        chk("sat", 32'(sat_a), 32'(o.sat_a));
        chk("sat_small", 32'(sat_b), 32'(o.sat_b));
        if (y_a) pulses++;
        $display("edge x=%0b v=%0b clr=%0b pat=%b ov=%0b -> y=%0b cnt=%0d cnt2=%0d sat2=%0b",
                 bx, bv, bc, pat, ov, y_a, cnt_a, cnt_b, sat_b);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
        logic [15:0] b;
        b = bits;
        for (int i = n - 1; i >= 0; i--) begin
            step(b[i], 1'b1, 1'b0);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async_y", 32'(y_a), 32'd0);
        chk("rst_async_cnt", 32'(cnt_a), 32'd0);
        chk("rst_async_cnt_small", 32'(cnt_b), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_sat", 32'(sat_b), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; x = 1'b0; x_valid = 1'b0; clr = 1'b0; pat = 4'b1011; ov = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_y", 32'(y_a), 32'd0);
        chk("reset_cnt", 32'(cnt_a), 32'd0);
        chk("reset_sat", 32'(sat_a), 32'd0);
        chk("reset_sat_small", 32'(sat_b), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1011 overlapping on 1011011
        pulses = 0; pat = 4'b1011; ov = 1'b1;
        send_bits(16'b1011011, 7, 0);
        chk("ov1_pulses", 32'(pulses), 32'd2);
        chk("ov1_cnt", 32'(cnt_a), 32'd2);

        // Same stream, non-overlapping
        step(1'b0, 1'b0, 1'b1);
        pulses = 0; ov = 1'b0;
        send_bits(16'b1011011, 7, 0);
        chk("ov0_pulses", 32'(pulses), 32'd1);
        chk("ov0_cnt", 32'(cnt_a), 32'd1);

        // 1111 on seven 1s, both modes
        step(1'b0, 1'b0, 1'b1);
        pulses = 0; pat = 4'b1111; ov = 1'b1;
        send_bits(16'b1111111, 7, 0);
        chk("ones_ov1_cnt", 32'(cnt_a), 32'd4);
        chk("ones_ov1_pulses", 32'(pulses), 32'd4);
        step(1'b0, 1'b0, 1'b1);
        pulses = 0; ov = 1'b0;
        send_bits(16'b1111111, 7, 0);
        chk("ones_ov0_cnt", 32'(cnt_a), 32'd1);
        chk("ones_ov0_pulses", 32'(pulses), 32'd1);

        // Gapped delivery of 1011
        step(1'b0, 1'b0, 1'b1);
        pulses = 0; pat = 4'b1011; ov = 1'b1;
        send_bits(16'b1011, 4, 3);
        chk("gap_pulses", 32'(pulses), 32'd1);

        // All-zero pattern must not fire from reset history
        pat = 4'b0000;
        do_reset();
        pulses = 0;
        send_bits(16'b000, 3, 0);
        chk("zero_early", 32'(pulses), 32'd0);
        send_bits(16'b0, 1, 0);
        chk("zero_fourth", 32'(pulses), 32'd1);

        // Counter saturation on the 2-bit instance, then clear beating x_valid
        step(1'b0, 1'b0, 1'b1);
        pat = 4'b1111; ov = 1'b1; pulses = 0;
        send_bits(16'b11111111, 8, 0);
        chk("sat_cnt_small", 32'(cnt_b), 32'd3);
        chk("sat_flag_small", 32'(sat_b), 32'd1);
        chk("sat_cnt_wide", 32'(cnt_a), 32'd5);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_cnt_small", 32'(cnt_b), 32'd0);
        chk("clr_y", 32'(y_a), 32'd0);
        pulses = 0;
        send_bits(16'b111, 3, 0);
        chk("clr_refill", 32'(pulses), 32'd0);
        send_bits(16'b1, 1, 0);
        chk("clr_fourth", 32'(pulses), 32'd1);

        // Reset mid-pattern discards partial history
        step(1'b0, 1'b0, 1'b1);
        pat = 4'b1011; ov = 1'b1;
        send_bits(16'b101, 3, 0);
        do_reset();
        pulses = 0;
        send_bits(16'b1, 1, 0);
        chk("midrst_no_pulse", 32'(pulses), 32'd0);
        send_bits(16'b1011, 4, 0);
        chk("midrst_pulse", 32'(pulses), 32'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
